// File: rtl/player_sprite_drawer_if.sv
// Request/pixel-write bundle between the position block, the sprite drawer and the framebuffer.
// No logic; the drawer's registered outputs appear on this bundle directly.
// px_ready is the only backpressure signal; update is a one-cycle request.
interface player_sprite_drawer_if;
    logic [9:0] in_x;
    logic [8:0] in_y;
    logic       update;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       px_color;
    logic       px_valid;
    logic       px_ready;
    logic       busy;
    logic       done;

    // Drawer side: takes requests and px_ready, produces pixel writes and status.
    modport slave (
        input  in_x, in_y, update, px_ready,
        output px_x, px_y, px_color, px_valid, busy, done
    );

    // Requester/framebuffer side.
    modport master (
        output in_x, in_y, update, px_ready,
        input  px_x, px_y, px_color, px_valid, busy, done
    );
endinterface

// File: rtl/player_sprite_drawer.sv
// Erases the sprite rectangle at the old position, then draws it at the new one.
// Latency: update in cycle N gives the first pixel offer in N+1; done one cycle after the last accept.
// Backpressure: px_ready low freezes the offered pixel; clipped pixels are skipped in one cycle each.
module player_sprite_drawer #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 8
) (
    input  logic CLOCK_50,
    input  logic reset,
    player_sprite_drawer_if.slave sif
);

    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Screen coordinate of one walk position plus its on-screen flag.
    typedef struct packed {
        logic       vld;
        logic [9:0] x;
        logic [8:0] y;
    } pix_t;

    // Sums are formed one bit wider than the ports so a sprite hanging off
    // the right/bottom edge is detected as clipped rather than wrapping to 0.
    function automatic pix_t pix_at(
        input logic [9:0]    bx,
        input logic [8:0]    by,
        input logic [CW-1:0] c,
        input logic [RW-1:0] r
    );
        logic [10:0] sx;
        logic [9:0]  sy;
        pix_t        p;
        sx    = {1'b0, bx} + 11'(c);
        sy    = {1'b0, by} + 10'(r);
        p.vld = (sx < 11'd640) && (sy < 10'd480);
        p.x   = sx[9:0];
        p.y   = sy[8:0];
        return p;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [9:0]    old_x_q, old_x_d;
    logic [8:0]    old_y_q, old_y_d;
    logic [9:0]    new_x_q, new_x_d;
    logic [8:0]    new_y_q, new_y_d;
    logic          has_old_q, has_old_d;
    logic          px_valid_q, px_valid_d;
    logic [9:0]    px_x_q, px_x_d;
    logic [8:0]    px_y_q, px_y_d;
    logic          px_color_q, px_color_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          last_pix;
    logic          advance;
    logic          load_pix;
    logic [9:0]    base_x;
    logic [8:0]    base_y;
    pix_t          nxt;

    // Next-state, walk counters and next registered pixel offer.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        has_old_d  = has_old_q;
        px_valid_d = px_valid_q;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_color_d = px_color_q;
        done_d     = 1'b0;
        load_pix   = 1'b0;
        nxt        = '0;
        advance    = 1'b0;
        last_pix   = (col_q == COL_LAST) && (row_q == ROW_LAST);
        base_x     = (state_q == ERASE) ? old_x_q : new_x_q;
        base_y     = (state_q == ERASE) ? old_y_q : new_y_q;

        unique case (state_q)
            IDLE: begin
                if (sif.update) begin
                    new_x_d = sif.in_x;
                    new_y_d = sif.in_y;
                    col_d   = '0;
                    row_d   = '0;
                    if (has_old_q && (sif.in_x == old_x_q) && (sif.in_y == old_y_q)) begin
                        // Sprite already sits there: nothing to repaint.
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else if (has_old_q) begin
                        state_d    = ERASE;
                        nxt        = pix_at(old_x_q, old_y_q, '0, '0);
                        load_pix   = 1'b1;
                        px_color_d = 1'b0;
                    end else begin
                        state_d    = DRAW;
                        nxt        = pix_at(sif.in_x, sif.in_y, '0, '0);
                        load_pix   = 1'b1;
                        px_color_d = 1'b1;
                    end
                end
            end

            ERASE, DRAW: begin
                // A clipped position is never offered, so it moves on without waiting for ready.
                advance = !px_valid_q || sif.px_ready;
                if (advance) begin
                    if (last_pix && (state_q == ERASE)) begin
                        state_d    = DRAW;
                        col_d      = '0;
                        row_d      = '0;
                        nxt        = pix_at(new_x_q, new_y_q, '0, '0);
                        load_pix   = 1'b1;
                        px_color_d = 1'b1;
                    end else if (last_pix) begin
                        state_d    = FINISH;
                        done_d     = 1'b1;
                        px_valid_d = 1'b0;
                        has_old_d  = 1'b1;
                        old_x_d    = new_x_q;
                        old_y_d    = new_y_q;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        nxt      = pix_at(base_x, base_y, col_d, row_d);
                        load_pix = 1'b1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_pix) begin
            px_valid_d = nxt.vld;
            px_x_d     = nxt.x;
            px_y_d     = nxt.y;
        end

        busy_d = (state_d != IDLE);
    end

    // All state and outputs registered; reset abandons any walk in progress.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            old_x_q    <= '0;
            old_y_q    <= '0;
            new_x_q    <= '0;
            new_y_q    <= '0;
            has_old_q  <= 1'b0;
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_color_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            has_old_q  <= has_old_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_color_q <= px_color_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sif.px_valid = px_valid_q;
    assign sif.px_x     = px_x_q;
    assign sif.px_y     = px_y_q;
    assign sif.px_color = px_color_q;
    assign sif.busy     = busy_q;
    assign sif.done     = done_q;

endmodule

// File: tb/tb_player_sprite_drawer.sv
module tb_player_sprite_drawer;

    localparam int W = 16;
    localparam int H = 8;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        c;
    } pix_t;

    logic clk;
    logic rst_n;

    player_sprite_drawer_if sif ();

    player_sprite_drawer #(.SPRITE_W(W), .SPRITE_H(H)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .sif      (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed results of the latest request.
    pix_t got[$];
    int   n_valid;
    int   n_done;
    int   first_lat;
    int   done_lat;
    int   stall_bad;
    logic busy_after;

    // Reference model state: what should be on screen, independent of the RTL.
    pix_t exp[$];
    int   exp_walk;
    bit   m_has_old;
    int   m_old_x;
    int   m_old_y;

    function automatic void model_walk(input int bx, input int by, input bit color);
        pix_t p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if ((bx + c) < 640 && (by + r) < 480) begin
                    p.x = 11'(bx + c);
                    p.y = 10'(by + r);
                    p.c = color;
                    exp.push_back(p);
                end
            end
        end
    endfunction

    task automatic model_request(input int x, input int y);
        exp.delete();
        exp_walk = 0;
        if (!(m_has_old && x == m_old_x && y == m_old_y)) begin
            if (m_has_old) begin
                model_walk(m_old_x, m_old_y, 1'b0);
                exp_walk += W * H;
            end
            model_walk(x, y, 1'b1);
            exp_walk += W * H;
            m_has_old = 1'b1;
            m_old_x   = x;
            m_old_y   = y;
        end
    endtask

    function automatic int count_diffs();
        int n = 0;
        if (got.size() != exp.size()) n++;
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            if (got[i] !== exp[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sif.update = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_has_old = 1'b0;
        m_old_x = 0;
        m_old_y = 0;
    endtask

    // Issues one update and records every offer/accept until one cycle past done.
    task automatic run_request(input int x, input int y, input int mode,
                               input int budget, input int abort_after);
        pix_t       p;
        bit         stall_prev;
        logic [9:0] sx;
        logic [8:0] sy;
        logic       sc;
        got.delete();
        n_valid = 0; n_done = 0; first_lat = -1; done_lat = -1; stall_bad = 0;
        busy_after = 1'b1;
        stall_prev = 1'b0; sx = '0; sy = '0; sc = 1'b0;
        @(posedge clk); #1;
        sif.in_x = 10'(x);
        sif.in_y = 9'(y);
        sif.update = 1'b1;
        sif.px_ready = 1'b1;
        @(negedge clk);
        if (sif.px_valid === 1'b1) n_valid++;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            sif.update = 1'b0;
            if (mode == 0)      sif.px_ready = 1'b1;
            else if (mode == 1) sif.px_ready = c[0];
            else                sif.px_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall_prev && (sif.px_valid !== 1'b1 || sif.px_x !== sx ||
                               sif.px_y !== sy || sif.px_color !== sc))
                stall_bad++;
            stall_prev = (sif.px_valid === 1'b1) && !sif.px_ready;
            sx = sif.px_x; sy = sif.px_y; sc = sif.px_color;
            if (sif.px_valid === 1'b1) begin
                n_valid++;
                if (first_lat < 0) first_lat = c;
                if (sif.px_ready) begin
                    p.x = {1'b0, sif.px_x};
                    p.y = {1'b0, sif.px_y};
                    p.c = sif.px_color;
                    got.push_back(p);
                end
            end
            if (sif.done === 1'b1) begin
                n_done++;
                if (done_lat < 0) done_lat = c;
            end
            if (abort_after > 0 && got.size() == abort_after) break;
            if (done_lat >= 0 && c == done_lat + 1) begin
                busy_after = sif.busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (sif.px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid got %b want 0", sif.px_valid); end
        checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", sif.busy); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", sif.done); end
        checks++; if (sif.px_color !== 1'b0) begin errors++; $display("FAIL reset_px_color got %b want 0", sif.px_color); end
        checks++; if (sif.px_x !== 10'd0) begin errors++; $display("FAIL reset_px_x got %0d want 0", sif.px_x); end
        checks++; if (sif.px_y !== 9'd0) begin errors++; $display("FAIL reset_px_y got %0d want 0", sif.px_y); end
        rst_n = 1'b1;
        m_has_old = 1'b0;
    endtask

    task automatic test_first_draw();
        model_request(320, 26);
        run_request(320, 26, 0, 400, 0);
        checks++; if (got.size() != 128) begin errors++; $display("FAIL first_draw_count got %0d want 128", got.size()); end
        checks++; if (count_diffs() != 0) begin errors++; $display("FAIL first_draw_seq got %0d diffs want 0", count_diffs()); end
        checks++; if (got.size() > 0 && (got[0].x != 320 || got[0].y != 26 || got[0].c != 1'b1))
            begin errors++; $display("FAIL first_draw_first got (%0d,%0d,%0d) want (320,26,1)", got[0].x, got[0].y, got[0].c); end
        checks++; if (got.size() > 0 && (got[got.size()-1].x != 335 || got[got.size()-1].y != 33))
            begin errors++; $display("FAIL first_draw_last got (%0d,%0d) want (335,33)", got[got.size()-1].x, got[got.size()-1].y); end
        checks++; if (first_lat != 1) begin errors++; $display("FAIL first_draw_latency got %0d want 1", first_lat); end
        checks++; if (done_lat != exp_walk + 1) begin errors++; $display("FAIL first_draw_done_cycle got %0d want %0d", done_lat, exp_walk + 1); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL first_draw_done_pulses got %0d want 1", n_done); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL first_draw_busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_move();
        model_request(325, 26);
        run_request(325, 26, 0, 600, 0);
        checks++; if (got.size() != 256) begin errors++; $display("FAIL move_count got %0d want 256", got.size()); end
        checks++; if (count_diffs() != 0) begin errors++; $display("FAIL move_seq got %0d diffs want 0", count_diffs()); end
        checks++; if (done_lat != exp_walk + 1) begin errors++; $display("FAIL move_done_cycle got %0d want %0d", done_lat, exp_walk + 1); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL move_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_no_move();
        model_request(325, 26);
        run_request(325, 26, 0, 50, 0);
        checks++; if (n_valid != 0) begin errors++; $display("FAIL no_move_valid_cycles got %0d want 0", n_valid); end
        checks++; if (done_lat != 1) begin errors++; $display("FAIL no_move_done_cycle got %0d want 1", done_lat); end
        checks++; if (n_done != 1 || busy_after !== 1'b0) begin errors++; $display("FAIL no_move_done got pulses %0d busy %b want 1/0", n_done, busy_after); end
    endtask

    task automatic test_backpressure();
        model_request(200, 100);
        run_request(200, 100, 1, 1500, 0);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got.size(), exp.size()); end
        checks++; if (count_diffs() != 0) begin errors++; $display("FAIL bp_seq got %0d diffs want 0", count_diffs()); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_clipping();
        do_reset();
        model_request(630, 476);
        run_request(630, 476, 0, 400, 0);
        checks++; if (got.size() != 40) begin errors++; $display("FAIL clip_count got %0d want 40", got.size()); end
        checks++; if (count_diffs() != 0) begin errors++; $display("FAIL clip_seq got %0d diffs want 0", count_diffs()); end
        checks++; if (done_lat != 129) begin errors++; $display("FAIL clip_done_cycle got %0d want 129", done_lat); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_request(320, 26, 0, 400, 50);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sif.px_valid !== 1'b0) begin errors++; $display("FAIL midrst_px_valid got %b want 0", sif.px_valid); end
        checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", sif.busy); end
        checks++; if (sif.px_x !== 10'd0 || sif.px_y !== 9'd0)
            begin errors++; $display("FAIL midrst_px_xy got (%0d,%0d) want (0,0)", sif.px_x, sif.px_y); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_has_old = 1'b0;
        model_request(100, 26);
        run_request(100, 26, 0, 400, 0);
        checks++; if (got.size() != 128) begin errors++; $display("FAIL midrst_redraw_count got %0d want 128", got.size()); end
        checks++; if (count_diffs() != 0) begin errors++; $display("FAIL midrst_redraw_seq got %0d diffs want 0", count_diffs()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL midrst_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_random();
        int x, y;
        x = m_old_x; y = m_old_y;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 511));
            end
            model_request(x, y);
            run_request(x, y, 2, 3000, 0);
            checks++; if (count_diffs() != 0) begin errors++; $display("FAIL rand%0d_seq at (%0d,%0d) got %0d diffs want 0", i, x, y, count_diffs()); end
            checks++; if (n_done != 1) begin errors++; $display("FAIL rand%0d_done_pulses got %0d want 1", i, n_done); end
            checks++; if (stall_bad != 0) begin errors++; $display("FAIL rand%0d_stall_stable got %0d want 0", i, stall_bad); end
            checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_after got %b want 0", i, busy_after); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sif.in_x = '0;
        sif.in_y = '0;
        sif.update = 1'b0;
        sif.px_ready = 1'b1;
        m_has_old = 1'b0;
        m_old_x = 0;
        m_old_y = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_first_draw();
        test_move();
        test_no_move();
        test_backpressure();
        test_clipping();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
